// File: rtl/content_loss_accum.sv
// rtl/content_loss_accum.sv - pipelined sum-of-squared-differences loss accumulator
module content_loss_accum #(
    parameter int LANES = 8,
    parameter int PIX_W = 16,
    parameter int ACC_W = 40,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [CNT_W-1:0]       num_beats,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*PIX_W-1:0] content_pixels,
    input  logic [LANES*PIX_W-1:0] generated_pixels,
    output logic [ACC_W-1:0]       loss_out,
    output logic                   loss_valid,
    input  logic                   loss_ready,
    output logic                   busy,
    output logic                   overflow
);
    localparam int SQ_W  = 2 * PIX_W;
    localparam int S_W   = SQ_W + $clog2(LANES);
    localparam int SUM_W = ((ACC_W > S_W) ? ACC_W : S_W) + 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] beat_cnt;
    logic [1:0]       drain_cnt;
    logic [SQ_W-1:0]  sq_r [LANES];
    logic             v1;
    logic [S_W-1:0]   lane_sum_r;
    logic             v2;
    logic [ACC_W-1:0] acc;

    logic [PIX_W-1:0] mag [LANES];
    logic [SQ_W-1:0]  sq_next [LANES];
    logic [S_W-1:0]   lane_sum;
    logic [SUM_W-1:0] sum_ext;
    logic             sat;
    logic             transfer;

    assign transfer = in_valid && in_ready;
    assign loss_out = acc;

    // |content - generated| squared equals the signed difference squared
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            mag[i] = (content_pixels[i*PIX_W +: PIX_W] >= generated_pixels[i*PIX_W +: PIX_W])
                   ? content_pixels[i*PIX_W +: PIX_W] - generated_pixels[i*PIX_W +: PIX_W]
                   : generated_pixels[i*PIX_W +: PIX_W] - content_pixels[i*PIX_W +: PIX_W];
            sq_next[i] = SQ_W'(mag[i]) * SQ_W'(mag[i]);
        end
        lane_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane_sum = lane_sum + S_W'(sq_r[i]);
        end
        sum_ext = SUM_W'(acc) + SUM_W'(lane_sum_r);
        sat     = |sum_ext[SUM_W-1:ACC_W];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            beat_cnt   <= '0;
            drain_cnt  <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            lane_sum_r <= '0;
            acc        <= '0;
            overflow   <= 1'b0;
            in_ready   <= 1'b0;
            loss_valid <= 1'b0;
            busy       <= 1'b0;
            for (int i = 0; i < LANES; i++) sq_r[i] <= '0;
        end else begin
            v1 <= transfer;
            if (transfer) begin
                for (int i = 0; i < LANES; i++) sq_r[i] <= sq_next[i];
            end
            v2 <= v1;
            if (v1) lane_sum_r <= lane_sum;
            if (v2) begin
                if (sat) begin
                    acc      <= '1;
                    overflow <= 1'b1;
                end else begin
                    acc <= sum_ext[ACC_W-1:0];
                end
            end

            // Pipeline is empty in IDLE, so the clear below never races an accumulate
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        overflow <= 1'b0;
                        busy     <= 1'b1;
                        if (num_beats != '0) begin
                            beat_cnt <= num_beats;
                            in_ready <= 1'b1;
                            state    <= RUN;
                        end else begin
                            loss_valid <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (transfer) begin
                        beat_cnt <= beat_cnt - CNT_W'(1);
                        if (beat_cnt == CNT_W'(1)) begin
                            in_ready  <= 1'b0;
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 2'd1;
                    if (drain_cnt == 2'd3) begin
                        loss_valid <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (loss_ready) begin
                        loss_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_content_loss_accum.sv
// tb/tb_content_loss_accum.sv - scoreboard bench for content_loss_accum (ACC_W 40 and 32)
module tb_content_loss_accum;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  num_beats;
    logic         in_valid;
    logic [127:0] content_pixels;
    logic [127:0] generated_pixels;
    logic         loss_ready;

    logic         in_ready0, lv0, busy0, ov0;
    logic [39:0]  lo0;
    logic         in_ready1, lv1, busy1, ov1;
    logic [31:0]  lo1;

    typedef struct {
        longint unsigned loss;
        bit              ovf;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_cmp  = 0;
    int   n_fail = 0;
    bit   held0 = 0, held1 = 0;
    logic [39:0] h_lo0;
    logic [31:0] h_lo1;
    logic h_ov0, h_ov1;
    logic [127:0] cb[4];
    logic [127:0] gb[4];

    content_loss_accum #(.LANES(8), .PIX_W(16), .ACC_W(40), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .start(start), .num_beats(num_beats),
        .in_valid(in_valid), .in_ready(in_ready0),
        .content_pixels(content_pixels), .generated_pixels(generated_pixels),
        .loss_out(lo0), .loss_valid(lv0), .loss_ready(loss_ready),
        .busy(busy0), .overflow(ov0)
    );

    content_loss_accum #(.LANES(8), .PIX_W(16), .ACC_W(32), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .start(start), .num_beats(num_beats),
        .in_valid(in_valid), .in_ready(in_ready1),
        .content_pixels(content_pixels), .generated_pixels(generated_pixels),
        .loss_out(lo1), .loss_valid(lv1), .loss_ready(loss_ready),
        .busy(busy1), .overflow(ov1)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no summary, required completion");
        $fatal(1);
    end

    // Monitors: pop on handshake, and check loss_out/overflow stay put while stalled
    always @(negedge clk) begin
        if (rst) held0 = 0;
        else if (lv0) begin
            if (held0) begin
                n_cmp++;
                if (lo0 !== h_lo0 || ov0 !== h_ov0) begin
                    n_fail++;
                    $display("FAIL hold40: got loss=%0d ovf=%0b, required held loss=%0d ovf=%0b", lo0, ov0, h_lo0, h_ov0);
                end
            end else begin
                held0 = 1; h_lo0 = lo0; h_ov0 = ov0;
            end
            if (loss_ready) begin
                held0 = 0;
                n_cmp++;
                if (q0.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected40: loss_valid with loss=%0d, required no result", lo0);
                end else begin
                    e0 = q0.pop_front();
                    if (64'(lo0) !== e0.loss || ov0 !== e0.ovf) begin
                        n_fail++;
                        $display("FAIL result40: got loss=%0d ovf=%0b, required loss=%0d ovf=%0b", lo0, ov0, e0.loss, e0.ovf);
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst) held1 = 0;
        else if (lv1) begin
            if (held1) begin
                n_cmp++;
                if (lo1 !== h_lo1 || ov1 !== h_ov1) begin
                    n_fail++;
                    $display("FAIL hold32: got loss=%0d ovf=%0b, required held loss=%0d ovf=%0b", lo1, ov1, h_lo1, h_ov1);
                end
            end else begin
                held1 = 1; h_lo1 = lo1; h_ov1 = ov1;
            end
            if (loss_ready) begin
                held1 = 0;
                n_cmp++;
                if (q1.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected32: loss_valid with loss=%0d, required no result", lo1);
                end else begin
                    e1 = q1.pop_front();
                    if (64'(lo1) !== e1.loss || ov1 !== e1.ovf) begin
                        n_fail++;
                        $display("FAIL result32: got loss=%0d ovf=%0b, required loss=%0d ovf=%0b", lo1, ov1, e1.loss, e1.ovf);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input longint unsigned got, input longint unsigned req);
        n_cmp++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    function automatic logic [127:0] fill(input logic [15:0] v);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    function automatic logic [127:0] ramp(input logic [15:0] step);
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = 16'(i) * step;
        return r;
    endfunction

    // Called at a negedge; start is seen by the following rising edge
    task automatic start_job(input int nb);
        start = 1'b1;
        num_beats = 16'(nb);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beats(input int nb, input bit [15:0] pat, input int plen, input bit spurious);
        int b = 0, p = 0, guard = 0;
        bit v, rdy;
        while (b < nb && guard < 200) begin
            v = (p < plen) ? pat[p] : 1'b1;
            p++;
            in_valid = v;
            content_pixels = cb[b];
            generated_pixels = gb[b];
            start = spurious && !v;
            num_beats = 16'd7;
            rdy = in_ready0;
            @(posedge clk);
            if (v && rdy) b++;
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        start = 1'b0;
        if (guard >= 200) check("beat_timeout", 64'(b), 64'(nb));
    endtask

    task automatic run_job(input string name, input int nb,
                           input longint unsigned x40, input bit o40,
                           input longint unsigned x32, input bit o32,
                           input bit [15:0] pat, input int plen,
                           input bit spurious, input int hold);
        int lat, guard;
        q0.push_back('{loss: x40, ovf: o40});
        q1.push_back('{loss: x32, ovf: o32});
        loss_ready = (hold == 0);
        start_job(nb);
        if (nb == 0) begin
            check({name, "_in_ready"}, 64'(in_ready0 | in_ready1), 0);
            check({name, "_valid_next"}, 64'(lv0 & lv1), 1);
        end else begin
            send_beats(nb, pat, plen, spurious);
            lat = 0;
            while (!lv0 && lat < 20) begin
                @(posedge clk);
                lat++;
                @(negedge clk);
            end
            check({name, "_latency"}, 64'(lat), 4);
        end
        if (hold > 0) begin
            repeat (hold) @(negedge clk);
            loss_ready = 1'b1;
        end
        guard = 0;
        while ((q0.size() != 0 || q1.size() != 0) && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check({name, "_drain_timeout"}, 64'(guard < 50), 1);
        @(negedge clk);
        check({name, "_valid_drop"}, 64'(lv0 | lv1 | busy0 | busy1), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_beats = '0; in_valid = 1'b0;
        content_pixels = '0; generated_pixels = '0; loss_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_outputs", 64'({in_ready0, lv0, busy0, ov0, in_ready1, lv1, busy1, ov1}), 0);
        check("reset_loss", 64'(lo0) + 64'(lo1), 0);
        rst = 1'b0;

        // First start on the first edge after reset release
        cb[0] = fill(16'd10); gb[0] = fill(16'd7);
        run_job("one_beat", 1, 72, 0, 72, 0, 16'h0, 0, 0, 0);

        cb[0] = fill(16'd0); gb[0] = fill(16'hFFFF);
        cb[1] = cb[0]; gb[1] = gb[0]; cb[2] = cb[0]; gb[2] = gb[0];
        run_job("max_diff", 3, 64'd103076069400, 0, 64'hFFFFFFFF, 1, 16'h0, 0, 0, 0);

        run_job("zero_beats", 0, 0, 0, 0, 0, 16'h0, 0, 0, 0);

        // lanes i*100: 10000*(0+1+4+...+49) = 1400000 per beat, either sign
        cb[0] = ramp(16'd100); gb[0] = fill(16'd0);
        cb[1] = fill(16'd0);   gb[1] = ramp(16'd100);
        run_job("ramp", 2, 2800000, 0, 2800000, 0, 16'h0, 0, 0, 0);

        // beat b differs by 3b on every lane: 8*(0+9+36+81) = 1008
        for (int b = 0; b < 4; b++) begin
            cb[b] = fill(16'(3 * b)); gb[b] = fill(16'd0);
        end
        run_job("contig", 4, 1008, 0, 1008, 0, 16'h0, 0, 0, 0);
        run_job("gapped", 4, 1008, 0, 1008, 0, 16'b1011001, 7, 1, 10);

        // Reset after two of four beats: no result may follow
        cb[0] = fill(16'd100); gb[0] = fill(16'd0);
        cb[1] = cb[0]; gb[1] = gb[0];
        start_job(4);
        send_beats(2, 16'h0, 0, 0);
        repeat (3) @(negedge clk);
        check("mid_run_busy", 64'(busy0 & busy1 & in_ready0), 1);
        check("mid_run_partial", 64'(lo0), 160000);
        #2 rst = 1'b1;
        #1;
        check("abort_outputs", 64'({in_ready0, lv0, busy0, ov0, in_ready1, lv1, busy1, ov1}), 0);
        check("abort_loss", 64'(lo0) + 64'(lo1), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        check("abort_no_valid", 64'(lv0 | lv1 | busy0 | busy1), 0);

        cb[0] = fill(16'd5); gb[0] = fill(16'd2);
        run_job("after_abort", 1, 72, 0, 72, 0, 16'h0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
